fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end replacing the fixed single-entry pc_reg/if_id pair.

---
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: in-order ROM requests, DEPTH-entry (pc, inst) queue,
// valid/ready delivery to ID, and branch flush that drops wrong-path responses.
module fetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [XLEN-1:0]  NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_ce_o,
  output logic [XLEN-1:0]            rom_addr_o,
  input  logic                       rom_ready_i,
  input  logic                       rom_rvalid_i,
  input  logic [XLEN-1:0]            rom_data_i,
  input  logic                       branch_flag_i,
  input  logic [XLEN-1:0]            branch_target_i,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output logic [XLEN-1:0]            id_pc_o,
  output logic [XLEN-1:0]            id_inst_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW:0]   DEPTH_E = (PW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   discard_cnt_q, discard_cnt_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] ent_pc_q [DEPTH];
  logic [XLEN-1:0] ent_pc_d [DEPTH];
  logic [XLEN-1:0] ent_inst_q [DEPTH];
  logic [XLEN-1:0] ent_inst_d [DEPTH];
  logic [DEPTH-1:0] ent_filled_q, ent_filled_d;

  logic [PW-1:0] count, inflight;
  logic [PW:0]   budget;
  logic [AW-1:0] wr_idx, fill_idx, rd_idx;
  logic          head_valid, fire, pop;
  logic          rsp_drop, rsp_fill, rsp_err;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign inflight = wr_ptr_q - fill_ptr_q;
  // Discarded responses still occupy ROM pipeline slots, so they count against the issue budget.
  assign budget   = {1'b0, inflight} + {1'b0, discard_cnt_q};
  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign fill_idx = fill_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];

  assign rom_ce_o   = rst & ~branch_flag_i & (count < DEPTH_P) & (budget < DEPTH_E);
  assign rom_addr_o = pc_q;
  assign fire       = rom_ce_o & rom_ready_i;

  assign head_valid = (count != '0) & ent_filled_q[rd_idx];
  assign pop        = head_valid & id_ready_i & ~branch_flag_i;

  assign rsp_drop = rom_rvalid_i & (discard_cnt_q != '0);
  assign rsp_fill = rom_rvalid_i & (discard_cnt_q == '0) & (inflight != '0);
  assign rsp_err  = rom_rvalid_i & (discard_cnt_q == '0) & (inflight == '0);

  assign id_valid_o = head_valid;
  assign id_pc_o    = head_valid ? ent_pc_q[rd_idx]   : '0;
  assign id_inst_o  = head_valid ? ent_inst_q[rd_idx] : NOP_INST;
  assign count_o    = count;
  assign err_o      = err_q;

  always_comb begin
    pc_d          = pc_q;
    wr_ptr_d      = wr_ptr_q;
    fill_ptr_d    = fill_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    discard_cnt_d = discard_cnt_q;
    err_d         = err_q;
    ent_pc_d      = ent_pc_q;
    ent_inst_d    = ent_inst_q;
    ent_filled_d  = ent_filled_q;

    if (fire) begin
      ent_pc_d[wr_idx]     = pc_q;
      ent_filled_d[wr_idx] = 1'b0;
      wr_ptr_d             = wr_ptr_q + PW'(1);
      pc_d                 = pc_q + XLEN'(4);
    end
    if (rsp_fill) begin
      ent_inst_d[fill_idx]   = rom_data_i;
      ent_filled_d[fill_idx] = 1'b1;
      fill_ptr_d             = fill_ptr_q + PW'(1);
    end
    if (rsp_drop) discard_cnt_d = discard_cnt_q - PW'(1);
    if (rsp_err)  err_d = 1'b1;
    if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);

    // Every request still outstanding after this cycle belongs to the wrong path.
    if (branch_flag_i) begin
      wr_ptr_d      = '0;
      fill_ptr_d    = '0;
      rd_ptr_d      = '0;
      pc_d          = branch_target_i;
      discard_cnt_d = discard_cnt_q + inflight - PW'(rsp_drop | rsp_fill);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      wr_ptr_q      <= '0;
      fill_ptr_q    <= '0;
      rd_ptr_q      <= '0;
      discard_cnt_q <= '0;
      err_q         <= 1'b0;
      ent_filled_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]   <= '0;
        ent_inst_q[i] <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_ptr_q    <= fill_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      discard_cnt_q <= discard_cnt_d;
      err_q         <= err_d;
      ent_filled_q  <= ent_filled_d;
      ent_pc_q      <= ent_pc_d;
      ent_inst_q    <= ent_inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order ROM model with one-cycle response latency,
// hand-computed expectations checked with immediate assertions.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            rom_ce_o;
  logic [XLEN-1:0] rom_addr_o;
  logic            rom_ready;
  logic            rom_rvalid;
  logic [XLEN-1:0] rom_data;
  logic            branch_flag;
  logic [XLEN-1:0] branch_target;
  logic            id_valid_o;
  logic            id_ready;
  logic [XLEN-1:0] id_pc_o;
  logic [XLEN-1:0] id_inst_o;
  logic [2:0]      count_o;
  logic            err_o;

  logic            rsp_en;
  logic            man_rvalid;
  logic            auto_rvalid;
  logic [XLEN-1:0] auto_data;
  logic [XLEN-1:0] pend [$];

  int compared   = 0;
  int mismatched = 0;
  int fires;

  assign rom_rvalid = auto_rvalid | man_rvalid;
  assign rom_data   = man_rvalid ? 32'hDEADBEEF : auto_data;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INST(32'h13)) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_ready_i     (rom_ready),
    .rom_rvalid_i    (rom_rvalid),
    .rom_data_i      (rom_data),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .id_valid_o      (id_valid_o),
    .id_ready_i      (id_ready),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .count_o         (count_o),
    .err_o           (err_o)
  );

  function automatic logic [XLEN-1:0] inst_of(input logic [XLEN-1:0] a);
    return a ^ 32'hCAFE0000;
  endfunction

  // In-order ROM: answers each accepted request one cycle later while rsp_en is high.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete();
      auto_rvalid <= 1'b0;
      auto_data   <= '0;
    end else begin
      if (rom_ce_o && rom_ready) pend.push_back(rom_addr_o);
      if (rsp_en && pend.size() > 0) begin
        auto_rvalid <= 1'b1;
        auto_data   <= inst_of(pend.pop_front());
      end else begin
        auto_rvalid <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic idr, input logic br,
                               input logic [XLEN-1:0] tgt, input logic ren, input logic man);
    @(negedge clk);
    rom_ready     = rdy;
    id_ready      = idr;
    branch_flag   = br;
    branch_target = tgt;
    rsp_en        = ren;
    man_rvalid    = man;
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b0;
    rom_ready = 1'b0; id_ready = 1'b0; branch_flag = 1'b0;
    branch_target = '0; rsp_en = 1'b1; man_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    rom_ready = 1'b0; id_ready = 1'b0; branch_flag = 1'b0;
    branch_target = '0; rsp_en = 1'b1; man_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ce",    32'(rom_ce_o),   32'h0);
    checkOutput("rst_valid", 32'(id_valid_o), 32'h0);
    checkOutput("rst_pc",    id_pc_o,         32'h0);
    checkOutput("rst_inst",  id_inst_o,       32'h13);
    checkOutput("rst_count", 32'(count_o),    32'h0);
    checkOutput("rst_err",   32'(err_o),      32'h0);

    // Streaming fetch with immediate responses and an always-ready consumer
    resetDut();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 1, 0, '0, 1, 0);
      checkOutput("t1_ce",   32'(rom_ce_o), 32'h1);
      checkOutput("t1_addr", rom_addr_o,    32'(4 * k));
      if (k < 2) begin
        checkOutput("t1_idle_valid", 32'(id_valid_o), 32'h0);
      end else begin
        checkOutput("t1_valid", 32'(id_valid_o), 32'h1);
        checkOutput("t1_pc",    id_pc_o,         32'(4 * (k - 2)));
        checkOutput("t1_inst",  id_inst_o,       inst_of(32'(4 * (k - 2))));
      end
    end
    checkOutput("t1_err",   32'(err_o),   32'h0);
    checkOutput("t1_count", 32'(count_o), 32'h2);

    // Stalled consumer fills the queue, then drains in order
    resetDut();
    fires = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 0, '0, 1, 0);
      if (rom_ce_o) fires++;
    end
    checkOutput("t2_fires",   32'(fires),      32'h4);
    checkOutput("t2_full_ce", 32'(rom_ce_o),   32'h0);
    checkOutput("t2_count",   32'(count_o),    32'h4);
    checkOutput("t2_valid",   32'(id_valid_o), 32'h1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 0, '0, 1, 0);
      checkOutput("t2_pop_valid", 32'(id_valid_o), 32'h1);
      checkOutput("t2_pop_pc",    id_pc_o,         32'(4 * k));
      checkOutput("t2_pop_inst",  id_inst_o,       inst_of(32'(4 * k)));
      if (k == 1) begin
        checkOutput("t2_resume_ce",   32'(rom_ce_o), 32'h1);
        checkOutput("t2_resume_addr", rom_addr_o,    32'h10);
      end
    end

    // Flush with two requests in flight; their late responses must be dropped
    resetDut();
    applyStimulus(1, 1, 0, '0, 0, 0);
    applyStimulus(1, 1, 0, '0, 0, 0);
    applyStimulus(1, 1, 1, 32'h100, 0, 0);
    checkOutput("t3_flush_ce", 32'(rom_ce_o), 32'h0);
    checkOutput("t3_count",    32'(count_o),  32'h2);
    applyStimulus(1, 1, 0, '0, 1, 0);
    checkOutput("t3_ce",    32'(rom_ce_o), 32'h1);
    checkOutput("t3_addr",  rom_addr_o,    32'h100);
    checkOutput("t3_count0", 32'(count_o), 32'h0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t3_wait_valid", 32'(id_valid_o), 32'h0);
      applyStimulus(1, 1, 0, '0, 1, 0);
    end
    checkOutput("t3_valid", 32'(id_valid_o), 32'h1);
    checkOutput("t3_pc",    id_pc_o,         32'h100);
    checkOutput("t3_inst",  id_inst_o,       inst_of(32'h100));
    checkOutput("t3_err",   32'(err_o),      32'h0);

    // Flush coinciding with a response and a ready consumer, one request in flight
    resetDut();
    applyStimulus(1, 1, 0, '0, 1, 0);
    applyStimulus(1, 1, 0, '0, 1, 0);
    applyStimulus(0, 1, 1, 32'h200, 1, 0);
    checkOutput("t4_head_valid", 32'(id_valid_o), 32'h1);
    checkOutput("t4_head_pc",    id_pc_o,         32'h0);
    checkOutput("t4_flush_ce",   32'(rom_ce_o),   32'h0);
    applyStimulus(1, 1, 0, '0, 1, 0);
    checkOutput("t4_ce",    32'(rom_ce_o),   32'h1);
    checkOutput("t4_addr",  rom_addr_o,      32'h200);
    checkOutput("t4_count", 32'(count_o),    32'h0);
    checkOutput("t4_valid0", 32'(id_valid_o), 32'h0);
    applyStimulus(1, 1, 0, '0, 1, 0);
    checkOutput("t4_valid1", 32'(id_valid_o), 32'h0);
    applyStimulus(1, 1, 0, '0, 1, 0);
    checkOutput("t4_valid", 32'(id_valid_o), 32'h1);
    checkOutput("t4_pc",    id_pc_o,         32'h200);
    checkOutput("t4_inst",  id_inst_o,       inst_of(32'h200));
    checkOutput("t4_err",   32'(err_o),      32'h0);

    // Unsolicited response sets the sticky error flag
    resetDut();
    applyStimulus(0, 0, 0, '0, 1, 1);
    checkOutput("t5_err_before", 32'(err_o),   32'h0);
    checkOutput("t5_count_before", 32'(count_o), 32'h0);
    applyStimulus(0, 0, 0, '0, 1, 0);
    checkOutput("t5_err",   32'(err_o),      32'h1);
    checkOutput("t5_count", 32'(count_o),    32'h0);
    checkOutput("t5_valid", 32'(id_valid_o), 32'h0);
    applyStimulus(1, 0, 0, '0, 1, 0);
    applyStimulus(1, 0, 0, '0, 1, 0);
    checkOutput("t5_err_held", 32'(err_o), 32'h1);

    // Asynchronous reset with a full queue and three requests outstanding
    resetDut();
    applyStimulus(1, 0, 0, '0, 1, 0);
    applyStimulus(1, 0, 0, '0, 0, 0);
    applyStimulus(1, 0, 0, '0, 0, 0);
    applyStimulus(1, 0, 0, '0, 0, 0);
    applyStimulus(1, 0, 0, '0, 0, 0);
    checkOutput("t6_count", 32'(count_o),    32'h4);
    checkOutput("t6_valid", 32'(id_valid_o), 32'h1);
    checkOutput("t6_pc",    id_pc_o,         32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_ce",    32'(rom_ce_o),   32'h0);
    checkOutput("t6_rst_valid", 32'(id_valid_o), 32'h0);
    checkOutput("t6_rst_inst",  id_inst_o,       32'h13);
    checkOutput("t6_rst_count", 32'(count_o),    32'h0);
    @(negedge clk);
    rst = 1'b1;
    rom_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
    #1;
    checkOutput("t6_rel_ce",   32'(rom_ce_o), 32'h1);
    checkOutput("t6_rel_addr", rom_addr_o,    32'h0);
    applyStimulus(1, 1, 0, '0, 1, 0);
    checkOutput("t6_rel_valid0", 32'(id_valid_o), 32'h0);
    applyStimulus(1, 1, 0, '0, 1, 0);
    checkOutput("t6_rel_valid", 32'(id_valid_o), 32'h1);
    checkOutput("t6_rel_pc",    id_pc_o,         32'h0);
    checkOutput("t6_rel_inst",  id_inst_o,       inst_of(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
